// File: rtl/stream_multiplexer_pkg.sv
// -----------------------------------------------------------------------------
// stream_multiplexer_pkg
//   Shared definitions for the stream_multiplexer_rr block and its arbiter.
//   - MODE_FIXED / MODE_RR : encodings of the runtime `mode` input.
//   - next_idx(idx, n)     : modulo-n increment used by the round-robin scan.
// -----------------------------------------------------------------------------
package stream_multiplexer_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Wraps to 0 once the incremented index reaches n, so an out-of-range
    // starting index also restarts the scan at channel 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage : stream_multiplexer_pkg

// File: rtl/stream_multiplexer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search for a requester
//   starts at ptr+1 and wraps modulo N, so the channel granted last time
//   (held in ptr by the caller) has the lowest priority.
//
//   Ports:
//     req       in  N   request vector (one bit per channel)
//     ptr       in  SW  index of the most recently granted channel
//     grant     out N   one-hot grant, all zero when nothing requests
//     grant_idx out SW  binary index of the granted channel (0 if none)
//     any_grant out 1   high when grant is non-zero
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_multiplexer_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          any_grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    int unsigned  scan_idx;
    logic [N-1:0] req_shift;

    // Visit every channel exactly once, in priority order; the first hit wins
    // and later hits are ignored through the any_grant guard.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        req_shift = '0;
        scan_idx  = 32'(ptr);
        for (int off = 0; off < N; off++) begin
            scan_idx  = next_idx(scan_idx, N);
            req_shift = req >> scan_idx;
            if (!any_grant && req_shift[0]) begin
                any_grant = 1'b1;
                grant     = ONE << scan_idx;
                grant_idx = SW'(scan_idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/stream_multiplexer_rr.sv
// -----------------------------------------------------------------------------
// stream_multiplexer_rr
//   N-channel, W-bit stream multiplexer with per-input valid/ready, a single
//   registered output slot and a runtime choice between fixed selection
//   (legacy: `sel` picks the channel) and round-robin arbitration. Each output
//   beat carries the index of its source channel, and accepted input beats are
//   counted in a wrapping counter.
//
//   Ports:
//     clk        in  1      rising-edge clock
//     rst_n      in  1      synchronous active-low reset
//     mode       in  1      0 = fixed select via sel, 1 = round-robin
//     sel        in  SW     channel select used in fixed mode
//     in_data    in  N*W    channel k on bits [k*W +: W]
//     in_valid   in  N      per-channel valid
//     in_ready   out N      per-channel ready (combinational, at most one set)
//     out_data   out W      registered output data
//     out_chan   out SW     source channel of out_data
//     out_valid  out 1      output slot holds a beat
//     out_ready  in  1      consumer accepts the held beat
//     xfer_count out CNT_W  accepted input beats, wrapping
// -----------------------------------------------------------------------------
module stream_multiplexer_rr
    import stream_multiplexer_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SW    = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Output stage and arbitration state
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SW-1:0]    out_chan_q,  out_chan_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [SW-1:0]    ptr_q,       ptr_d;

    // Arbitration results
    logic [N-1:0]  rr_grant;
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic [N-1:0]  fixed_req;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          any_grant;
    logic [W-1:0]  grant_data;
    logic          can_load;
    logic          accept;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // Fixed mode looks only at the selected channel, so other channels' valid
    // bits can never influence in_ready. A select beyond N-1 grants nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        fixed_req = '0;
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
            any_grant = rr_any;
        end else if (int'(sel) < N) begin
            fixed_req = in_valid >> sel;
            if (fixed_req[0]) begin
                grant     = ONE << sel;
                grant_idx = sel;
                any_grant = 1'b1;
            end
        end
    end

    // One-hot grant drives an AND-OR data select.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_data = in_data[k*W +: W];
            end
        end
    end

    // The slot may be refilled in the same cycle it drains, giving full
    // throughput. rst_n gates ready so nothing looks accepted during reset.
    assign can_load = !out_valid_q || out_ready;
    assign accept   = any_grant && can_load;
    assign in_ready = grant & {N{can_load && rst_n}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            cnt_d       = cnt_q + CNT_W'(1);
            // The pointer only advances on round-robin grants; fixed-mode
            // traffic leaves the rotation where it was.
            if (mode == MODE_RR) begin
                ptr_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---- registered output stage ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            cnt_q       <= '0;
            ptr_q       <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign xfer_count = cnt_q;

endmodule : stream_multiplexer_rr

// File: tb/tb_stream_multiplexer_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_multiplexer_rr
//   Bench for stream_multiplexer_rr with N=4, W=8 and a 4-bit transfer
//   counter so the wrap is reachable quickly. A behavioural model (one output
//   slot, an integer pointer, an integer count) tracks the expected state
//   every cycle; directed steps add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_stream_multiplexer_rr;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SW    = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [SW-1:0]    sel;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_count;
    int         m_ptr;

    stream_multiplexer_rr #(
        .N     (N),
        .W     (W),
        .SW    (SW),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    // Which channel the rules say should win this cycle, or -1.
    function automatic int model_grant();
        int c;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (((in_valid >> c) & 4'b0001) != 4'b0000) return c;
        end
        return -1;
    endfunction

    // One clock: check ready against the model, advance model and DUT,
    // then check the registered outputs.
    task automatic step();
        int         g;
        bit         cl;
        logic [3:0] exp_rdy;
        #1;
        g       = model_grant();
        cl      = !m_valid || out_ready;
        exp_rdy = (rst_n && cl && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 8'h00; m_chan = 0; m_count = 0; m_ptr = N - 1;
        end else if (g >= 0 && cl) begin
            m_valid = 1;
            m_data  = 8'(in_data >> (g * W));
            m_chan  = g;
            m_count = (m_count + 1) % (1 << CNT_W);
            if (mode) m_ptr = g;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_chan", 32'(out_chan), 32'(m_chan));
        chk("xfer_count", 32'(xfer_count), 32'(m_count));
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        m_valid = 0; m_data = 8'h00; m_chan = 0; m_count = 0; m_ptr = N - 1;
        @(posedge clk);
        step();

        // Load a beat and hold it, then reset over it with inputs still active.
        rst_n = 1'b1; in_valid = 4'b0001; set_data(8'h11, 8'h22, 8'h33, 8'h44);
        step();
        chk("held_before_reset", 32'(out_valid), 32'd1);
        rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);

        // Fixed select of channel 2.
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        step();
        chk("fixed_data", 32'(out_data), 32'hA5);
        chk("fixed_chan", 32'(out_chan), 32'd2);
        chk("fixed_count", 32'(xfer_count), 32'd1);

        // Fixed-mode isolation: unselected valids are ignored.
        in_valid = 4'b0000;
        step();
        sel = 2'd1; in_valid = 4'b1101;
        #1;
        chk("iso_ready_sel1", 32'(in_ready), 32'd0);
        step();
        chk("iso_out_valid", 32'(out_valid), 32'd0);
        sel = 2'd3;
        #1;
        chk("iso_ready_sel3", 32'(in_ready), 32'b1000);
        step();

        // Round-robin fairness from a fresh reset (pointer at N-1).
        rst_n = 1'b0; in_valid = 4'b0000;
        step();
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(8'd0, 8'd1, 8'd2, 8'd3);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_chan", 32'(out_chan), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'(i % 4));
        end
        chk("rr_count", 32'(xfer_count), 32'd6);

        // Backpressure with 0x3C held, then drain and load in one cycle.
        in_valid = 4'b0000;
        step();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
        set_data(8'h3C, 8'h77, 8'h00, 8'h00);
        step();
        in_valid = 4'b0010; sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_data", 32'(out_data), 32'h3C);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_data", 32'(out_data), 32'h77);
        chk("nobubble_chan", 32'(out_chan), 32'd1);

        // Round-robin skip and wrap with pointer parked at 2.
        in_valid = 4'b0000;
        step();
        mode = 1'b1; in_valid = 4'b0100;
        step();
        in_valid = 4'b0011;
        step();
        chk("skip_chan0", 32'(out_chan), 32'd0);
        step();
        chk("skip_chan1", 32'(out_chan), 32'd1);
        step();
        chk("skip_chan0b", 32'(out_chan), 32'd0);

        // 17 beats through a 4-bit counter.
        rst_n = 1'b0; in_valid = 4'b0000;
        step();
        rst_n = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 17; i++) step();
        chk("count_wrap", 32'(xfer_count), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stream_multiplexer_rr
